// File: rtl/noc_pkg.sv
// Shared router constants: port indices, crossbar select encoding and flit flag layout.
package noc_pkg;

  localparam int unsigned N_PORTS = 5;
  localparam int unsigned SEL_W   = 3;
  localparam logic [SEL_W-1:0] SEL_NONE = 3'd7;

  localparam int unsigned PORT_L = 0;
  localparam int unsigned PORT_N = 1;
  localparam int unsigned PORT_E = 2;
  localparam int unsigned PORT_S = 3;
  localparam int unsigned PORT_W = 4;

  localparam int unsigned FLAG_W        = 2;
  localparam int unsigned FLIT_HEAD_BIT = 0;
  localparam int unsigned FLIT_TAIL_BIT = 1;

  typedef enum logic {
    LK_IDLE   = 1'b0,
    LK_LOCKED = 1'b1
  } lock_state_e;

  // Round-robin successor over the five port indices, wrapping 4 -> 0.
  function automatic logic [SEL_W-1:0] rr_next(input logic [SEL_W-1:0] idx);
    return (idx == SEL_W'(N_PORTS - 1)) ? '0 : idx + SEL_W'(1);
  endfunction

endpackage

// File: rtl/output_arbiter.sv
// Per-output wormhole arbiter: round-robin among head flits while idle, then
// holds the output for the winning input until its tail flit passes.
module output_arbiter
  import noc_pkg::*;
#(
  parameter int unsigned OUT_IDX = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_PORTS-1:0]       req_ok_i,
  input  logic [N_PORTS*SEL_W-1:0] req_dest_i,
  input  logic [N_PORTS-1:0]       req_head_i,
  input  logic [N_PORTS-1:0]       req_tail_i,
  input  logic                     out_ready_i,
  output logic [SEL_W-1:0]         sel_o,
  output logic [N_PORTS-1:0]       grant_o,
  output logic                     valid_o,
  output logic                     locked_o,
  output logic [SEL_W-1:0]         owner_o
);

  localparam int unsigned SUM_W = SEL_W + 1;

  lock_state_e        state_q, state_d;
  logic [SEL_W-1:0]   owner_q, owner_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [N_PORTS-1:0] match;
  logic [SUM_W-1:0]   sum;
  logic [SEL_W-1:0]   cand;
  logic               found;

  // Inputs whose error-free flit is destined for this output.
  always_comb begin
    match = '0;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      match[i] = req_ok_i[i] && (req_dest_i[SEL_W*i +: SEL_W] == SEL_W'(OUT_IDX));
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    sel_o   = SEL_NONE;
    grant_o = '0;
    valid_o = 1'b0;
    sum     = '0;
    cand    = '0;
    found   = 1'b0;
    if (!rst) begin
      if (state_q == LK_LOCKED) begin
        if (match[owner_q] && out_ready_i) begin
          sel_o            = owner_q;
          grant_o[owner_q] = 1'b1;
          valid_o          = 1'b1;
          if (req_tail_i[owner_q]) state_d = LK_IDLE;
        end
      end else if (out_ready_i) begin
        // Scan ptr, ptr+1, ... mod N_PORTS; first head flit wins.
        for (int unsigned k = 0; k < N_PORTS; k++) begin
          sum  = {1'b0, ptr_q} + SUM_W'(k);
          cand = (sum >= SUM_W'(N_PORTS)) ? SEL_W'(sum - SUM_W'(N_PORTS)) : SEL_W'(sum);
          if (!found && match[cand] && req_head_i[cand]) begin
            found         = 1'b1;
            sel_o         = cand;
            grant_o[cand] = 1'b1;
            valid_o       = 1'b1;
            ptr_d         = rr_next(cand);
            if (!req_tail_i[cand]) begin
              state_d = LK_LOCKED;
              owner_d = cand;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LK_IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

  assign locked_o = (state_q == LK_LOCKED);
  assign owner_o  = owner_q;

endmodule

// File: rtl/switch_allocator.sv
// Wormhole switch allocator for the 5-port router: one arbiter per output,
// protocol-error filtering of requests, and zero-latency grant/select.
module switch_allocator
  import noc_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_PORTS-1:0]       req_valid,
  input  logic [N_PORTS*SEL_W-1:0] req_dest,
  input  logic [N_PORTS-1:0]       req_head,
  input  logic [N_PORTS-1:0]       req_tail,
  input  logic [N_PORTS-1:0]       out_ready,
  output logic [N_PORTS-1:0]       grant,
  output logic [SEL_W-1:0]         Select_L,
  output logic [SEL_W-1:0]         Select_N,
  output logic [SEL_W-1:0]         Select_E,
  output logic [SEL_W-1:0]         Select_S,
  output logic [SEL_W-1:0]         Select_W,
  output logic [N_PORTS-1:0]       out_valid,
  output logic                     err_pulse
);

  logic [FLAG_W-1:0]  flags [N_PORTS];
  logic [N_PORTS-1:0] head_v, tail_v;
  logic [N_PORTS-1:0] bad, req_ok;
  logic [SEL_W-1:0]   d;
  logic               owns_any, owns_dest;

  logic [SEL_W-1:0]   arb_sel   [N_PORTS];
  logic [N_PORTS-1:0] arb_gnt   [N_PORTS];
  logic [SEL_W-1:0]   arb_owner [N_PORTS];
  logic [N_PORTS-1:0] arb_valid, arb_locked;

  // Per-input flit flags in the shared head/tail bit layout.
  always_comb begin
    head_v = '0;
    tail_v = '0;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      flags[i]                = '0;
      flags[i][FLIT_HEAD_BIT] = req_head[i];
      flags[i][FLIT_TAIL_BIT] = req_tail[i];
      head_v[i]               = flags[i][FLIT_HEAD_BIT];
      tail_v[i]               = flags[i][FLIT_TAIL_BIT];
    end
  end

  // Bad flits: illegal destination, body flit without a lock on its
  // destination, or a new head while the input still owns an output.
  always_comb begin
    bad       = '0;
    d         = '0;
    owns_any  = 1'b0;
    owns_dest = 1'b0;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      d         = req_dest[SEL_W*i +: SEL_W];
      owns_any  = 1'b0;
      owns_dest = 1'b0;
      for (int unsigned o = 0; o < N_PORTS; o++) begin
        if (arb_locked[o] && (arb_owner[o] == SEL_W'(i))) begin
          owns_any = 1'b1;
          if (d == SEL_W'(o)) owns_dest = 1'b1;
        end
      end
      bad[i] = req_valid[i] &&
               ((d > SEL_W'(N_PORTS - 1)) || (head_v[i] ? owns_any : !owns_dest));
    end
  end

  assign req_ok    = req_valid & ~bad;
  assign err_pulse = !rst && (|bad);

  for (genvar o = 0; o < N_PORTS; o++) begin : g_arb
    output_arbiter #(
      .OUT_IDX(o)
    ) u_arb (
      .clk         (clk),
      .rst         (rst),
      .req_ok_i    (req_ok),
      .req_dest_i  (req_dest),
      .req_head_i  (head_v),
      .req_tail_i  (tail_v),
      .out_ready_i (out_ready[o]),
      .sel_o       (arb_sel[o]),
      .grant_o     (arb_gnt[o]),
      .valid_o     (arb_valid[o]),
      .locked_o    (arb_locked[o]),
      .owner_o     (arb_owner[o])
    );
  end

  always_comb begin
    grant = '0;
    for (int unsigned o = 0; o < N_PORTS; o++) begin
      grant = grant | arb_gnt[o];
    end
  end

  assign out_valid = arb_valid;
  assign Select_L  = arb_sel[PORT_L];
  assign Select_N  = arb_sel[PORT_N];
  assign Select_E  = arb_sel[PORT_E];
  assign Select_S  = arb_sel[PORT_S];
  assign Select_W  = arb_sel[PORT_W];

endmodule

// File: tb/tb_switch_allocator.sv
// Directed bench for switch_allocator with a packet-level reference model.
module tb_switch_allocator;

  logic        clk, rst;
  logic [4:0]  req_valid, req_head, req_tail, out_ready;
  logic [14:0] req_dest;
  logic [4:0]  grant, out_valid;
  logic [2:0]  sel_l, sel_n, sel_e, sel_s, sel_w;
  logic        err_pulse;

  switch_allocator dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_dest(req_dest),
    .req_head(req_head), .req_tail(req_tail), .out_ready(out_ready),
    .grant(grant),
    .Select_L(sel_l), .Select_N(sel_n), .Select_E(sel_e),
    .Select_S(sel_s), .Select_W(sel_w),
    .out_valid(out_valid), .err_pulse(err_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] act_sel [5];
  assign act_sel[0] = sel_l;
  assign act_sel[1] = sel_n;
  assign act_sel[2] = sel_e;
  assign act_sel[3] = sel_s;
  assign act_sel[4] = sel_w;

  int n_vec, n_bad;

  // Reference model: packet owner per output (-1 = free) and round-robin start.
  int own [5], rr [5], own_n [5], rr_n [5];
  int e_sel [5];
  int e_gnt, e_ov, e_err;

  function automatic logic [14:0] dests(int d0, int d1, int d2, int d3, int d4);
    return {3'(d4), 3'(d3), 3'(d2), 3'(d1), 3'(d0)};
  endfunction

  function automatic int dest_of(int i);
    logic [2:0] v;
    v = req_dest[3*i +: 3];
    return int'(v);
  endfunction

  task automatic check(string nm, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int o = 0; o < 5; o++) begin
      own[o] = -1;
      rr[o]  = 0;
    end
  endtask

  task automatic model_eval();
    bit bad [5];
    bit won;
    int k, cnd;
    e_gnt = 0; e_ov = 0; e_err = 0;
    for (int o = 0; o < 5; o++) begin
      e_sel[o] = 7;
      own_n[o] = own[o];
      rr_n[o]  = rr[o];
    end
    if (rst) begin
      for (int o = 0; o < 5; o++) begin
        own_n[o] = -1;
        rr_n[o]  = 0;
      end
      return;
    end
    for (int i = 0; i < 5; i++) begin
      bad[i] = 1'b0;
      if (req_valid[i]) begin
        if (dest_of(i) > 4) bad[i] = 1'b1;
        else if (req_head[i]) begin
          for (int o = 0; o < 5; o++) if (own[o] == i) bad[i] = 1'b1;
        end else if (own[dest_of(i)] != i) bad[i] = 1'b1;
      end
      if (bad[i]) e_err = 1;
    end
    for (int o = 0; o < 5; o++) begin
      if (own[o] >= 0) begin
        k = own[o];
        if (req_valid[k] && !bad[k] && dest_of(k) == o && out_ready[o]) begin
          e_sel[o] = k;
          e_gnt |= (1 << k);
          e_ov  |= (1 << o);
          if (req_tail[k]) own_n[o] = -1;
        end
      end else if (out_ready[o]) begin
        won = 1'b0;
        for (int j = 0; j < 5; j++) begin
          cnd = (rr[o] + j) % 5;
          if (!won && req_valid[cnd] && !bad[cnd] && req_head[cnd] && dest_of(cnd) == o) begin
            won = 1'b1;
            e_sel[o] = cnd;
            e_gnt |= (1 << cnd);
            e_ov  |= (1 << o);
            rr_n[o] = (cnd + 1) % 5;
            if (!req_tail[cnd]) own_n[o] = cnd;
          end
        end
      end
    end
  endtask

  task automatic compare_all(string tag);
    model_eval();
    check({tag, ".grant"}, int'(grant), e_gnt);
    for (int o = 0; o < 5; o++) check($sformatf("%s.sel%0d", tag, o), int'(act_sel[o]), e_sel[o]);
    check({tag, ".out_valid"}, int'(out_valid), e_ov);
    check({tag, ".err"}, int'(err_pulse), e_err);
  endtask

  task automatic commit();
    for (int o = 0; o < 5; o++) begin
      own[o] = own_n[o];
      rr[o]  = rr_n[o];
    end
  endtask

  // Drive one cycle, compare mid-cycle, optional literal pins, then advance.
  task automatic step(string tag, logic [4:0] v, logic [14:0] d, logic [4:0] h,
                      logic [4:0] t, logic [4:0] r,
                      int lit_o, int lit_sel, int lit_gnt, int lit_err);
    req_valid = v; req_dest = d; req_head = h; req_tail = t; out_ready = r;
    @(negedge clk);
    compare_all(tag);
    if (lit_o >= 0)   check({tag, ".lit_sel"}, int'(act_sel[lit_o]), lit_sel);
    if (lit_gnt >= 0) check({tag, ".lit_gnt"}, int'(grant), lit_gnt);
    if (lit_err >= 0) check({tag, ".lit_err"}, int'(err_pulse), lit_err);
    @(posedge clk);
    commit();
    #1;
  endtask

  int rr_seq [5] = '{1, 3, 4, 1, 3};

  initial begin
    n_vec = 0; n_bad = 0;
    rst = 1'b1;
    req_valid = '0; req_dest = '0; req_head = '0; req_tail = '0; out_ready = '0;
    model_reset();
    @(posedge clk); #1;

    // Requests during reset are ignored.
    step("reset", 5'b11111, dests(1, 2, 3, 4, 0), 5'b11111, 5'b11111, 5'b11111, 2, 7, 0, 0);
    rst = 1'b0;

    step("sf", 5'b00001, dests(2, 0, 0, 0, 0), 5'b00001, 5'b00001, 5'b11111, 2, 0, 5'b00001, 0);
    step("sf_idle", 5'b00000, dests(0, 0, 0, 0, 0), 5'b0, 5'b0, 5'b11111, 2, 7, 0, 0);

    for (int j = 0; j < 5; j++)
      step($sformatf("rr%0d", j), 5'b11010, dests(0, 0, 0, 0, 0), 5'b11010, 5'b11010,
           5'b11111, 0, rr_seq[j], 1 << rr_seq[j], 0);

    step("wh1", 5'b10010, dests(0, 3, 0, 0, 3), 5'b10010, 5'b00000, 5'b11111, 3, 1, 5'b00010, 0);
    step("wh2", 5'b10010, dests(0, 3, 0, 0, 3), 5'b10000, 5'b00000, 5'b11111, 3, 1, 5'b00010, 0);
    step("wh3", 5'b10010, dests(0, 3, 0, 0, 3), 5'b10000, 5'b00010, 5'b11111, 3, 1, 5'b00010, 0);
    step("wh4", 5'b10000, dests(0, 3, 0, 0, 3), 5'b10000, 5'b10000, 5'b11111, 3, 4, 5'b10000, 0);

    step("bp_head", 5'b00010, dests(0, 3, 0, 0, 0), 5'b00010, 5'b0, 5'b11111, 3, 1, 5'b00010, 0);
    step("bp_stall1", 5'b00010, dests(0, 3, 0, 0, 0), 5'b0, 5'b0, 5'b10111, 3, 7, 0, 0);
    step("bp_stall2", 5'b00010, dests(0, 3, 0, 0, 0), 5'b0, 5'b0, 5'b10111, 3, 7, 0, 0);
    step("bp_bubble", 5'b00000, dests(0, 3, 0, 0, 0), 5'b0, 5'b0, 5'b11111, 3, 7, 0, 0);
    step("bp_tail", 5'b00010, dests(0, 3, 0, 0, 0), 5'b0, 5'b00010, 5'b11111, 3, 1, 5'b00010, 0);

    step("err_body", 5'b00100, dests(0, 0, 0, 0, 0), 5'b0, 5'b0, 5'b11111, 0, 7, 0, 1);
    step("err_dest", 5'b00001, dests(5, 0, 0, 0, 0), 5'b00001, 5'b00001, 5'b11111, -1, 0, 0, 1);
    step("err_clear", 5'b00000, dests(0, 0, 0, 0, 0), 5'b0, 5'b0, 5'b11111, -1, 0, 0, 0);
    step("own_head", 5'b00010, dests(0, 3, 0, 0, 0), 5'b00010, 5'b0, 5'b11111, 3, 1, 5'b00010, 0);
    step("own_rehead", 5'b00010, dests(0, 3, 0, 0, 0), 5'b00010, 5'b0, 5'b11111, 3, 7, 0, 1);
    step("own_tail", 5'b00010, dests(0, 3, 0, 0, 0), 5'b0, 5'b00010, 5'b11111, 3, 1, 5'b00010, 0);

    step("mr_head", 5'b10000, dests(0, 0, 0, 0, 3), 5'b10000, 5'b0, 5'b11111, 3, 4, 5'b10000, 0);
    req_valid = 5'b10000; req_dest = dests(0, 0, 0, 0, 3); req_head = '0; req_tail = '0;
    #2;
    rst = 1'b1;
    #1;
    compare_all("mr_async");
    check("mr_async.lit_sel", int'(sel_s), 7);
    check("mr_async.lit_gnt", int'(grant), 0);
    commit();
    @(posedge clk); #1;
    rst = 1'b0;
    step("mr_new", 5'b10000, dests(0, 0, 0, 0, 3), 5'b10000, 5'b10000, 5'b11111, 3, 4, 5'b10000, 0);
    step("final", 5'b00000, dests(0, 0, 0, 0, 0), 5'b0, 5'b0, 5'b11111, 3, 7, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
